// File: rtl/eth_udp_tx_sched_pkg.sv
// Shared types and constants for the two-source UDP transmit scheduler.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // Largest UDP payload that fits a 1500-byte MTU without fragmentation.
    localparam int MAX_UDP_PAYLOAD = 1472;

    // The engine edge-detects tx_start_en through two flops, so it needs
    // at least three cycles of high level to register the start.
    localparam int MIN_START_HOLD = 3;

endpackage

// File: rtl/eth_udp_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the source not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic       valid,
    output logic       idx
);

    logic last;

    // Winner select: tie goes to the opposite of the last grant.
    always_comb begin
        valid = |req;
        idx   = (&req) ? ~last : req[1];
    end

    // Last-grant register; resets to 1 so src0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (accept && valid)
            last <= idx;
    end

endmodule

// File: rtl/eth_udp_tx_sched.sv
// Round-robin scheduler feeding the shared UDP/IP transmit engine from two
// packet sources, with start hold, inter-packet gap and stall watchdog.
module eth_udp_tx_sched
    import eth_tx_pkg::*;
#(
    parameter int START_HOLD     = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_PAYLOAD    = MAX_UDP_PAYLOAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src0_req,
    input  logic [15:0] src0_byte_num,
    input  logic [47:0] src0_des_mac,
    input  logic [31:0] src0_des_ip,
    input  logic [31:0] src0_data,
    output logic        src0_grant,
    output logic        src0_rd_en,
    output logic        src0_done,
    input  logic        src1_req,
    input  logic [15:0] src1_byte_num,
    input  logic [47:0] src1_des_mac,
    input  logic [31:0] src1_des_ip,
    input  logic [31:0] src1_data,
    output logic        src1_grant,
    output logic        src1_rd_en,
    output logic        src1_done,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        busy,
    output logic        len_err,
    output logic        timeout_err,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1
);

    // A too-short hold would let the engine miss the start, so clamp it.
    localparam int HOLD = (START_HOLD < MIN_START_HOLD) ? MIN_START_HOLD : START_HOLD;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);
    localparam logic [15:0] GAP_LAST  = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);

    state_t      state, nxt;
    logic [15:0] cnt;
    logic        sel;
    logic        arb_valid, arb_idx, arb_accept;
    logic [15:0] win_len;
    logic        win_ok;
    logic        granted;
    logic        wd_exp;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({src1_req, src0_req}),
        .accept (arb_accept),
        .valid  (arb_valid),
        .idx    (arb_idx)
    );

    // Winner length check; zero and oversize requests are rejected without a start.
    always_comb begin
        arb_accept = (state == IDLE);
        win_len    = arb_idx ? src1_byte_num : src0_byte_num;
        win_ok     = (win_len != 16'd0) && (win_len <= MAX_LEN);
        wd_exp     = (cnt == WD_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next-state logic; tx_done only counts once the start hold is over.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (arb_valid) nxt = win_ok ? START : GAP;
            START:     if (cnt == HOLD_LAST) nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done || wd_exp) nxt = GAP;
            GAP:       if (cnt == GAP_LAST) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // Per-state cycle counter: start hold, watchdog and gap share it.
    always_ff @(posedge clk) begin
        if (rst || (state != nxt))
            cnt <= 16'd0;
        else
            cnt <= cnt + 16'd1;
    end

    // State-decoded outputs and the granted source's data path.
    always_comb begin
        granted     = (state == START) || (state == WAIT_DONE);
        tx_start_en = (state == START);
        busy        = (state != IDLE);
        src0_grant  = granted && !sel;
        src1_grant  = granted &&  sel;
        src0_rd_en  = tx_req && src0_grant;
        src1_rd_en  = tx_req && src1_grant;
        tx_data     = sel ? src1_data : src0_data;
    end

    // Latched packet parameters, completion/error pulses and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel         <= 1'b0;
            tx_byte_num <= 16'd0;
            des_mac     <= 48'd0;
            des_ip      <= 32'd0;
            src0_done   <= 1'b0;
            src1_done   <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            pkt_cnt0    <= 16'd0;
            pkt_cnt1    <= 16'd0;
        end else begin
            src0_done   <= 1'b0;
            src1_done   <= 1'b0;
            len_err     <= 1'b0;
            timeout_err <= 1'b0;
            if (state == IDLE && arb_valid) begin
                if (win_ok) begin
                    sel         <= arb_idx;
                    tx_byte_num <= win_len;
                    des_mac     <= arb_idx ? src1_des_mac : src0_des_mac;
                    des_ip      <= arb_idx ? src1_des_ip  : src0_des_ip;
                end else begin
                    len_err   <= 1'b1;
                    src0_done <= !arb_idx;
                    src1_done <=  arb_idx;
                end
            end else if (state == WAIT_DONE && (tx_done || wd_exp)) begin
                src0_done   <= !sel;
                src1_done   <=  sel;
                timeout_err <= !tx_done;
                if (tx_done) begin
                    if (sel) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                    else     pkt_cnt0 <= pkt_cnt0 + 16'd1;
                end
            end
        end
    end

endmodule

// File: doc/eth_udp_tx_sched.md
# eth_udp_tx_sched

Two-source packet scheduler for the shared UDP/IP transmit engine in the Ethernet video path. Two packet sources (e.g. two video line/packet FIFOs) raise requests with payload length and destination. The block grants one source at a time, round-robin, and drives the engine's start/length/address inputs. It forwards the engine's data-request strobe and data bus for the granted source, enforces an inter-packet gap, and recovers from a stalled engine with a watchdog.

## Interface
Parameters:
- START_HOLD, 4: cycles tx_start_en is held high per packet (engine edge-detects through two flops; ≥3 required).
- IFG_CYCLES, 12: idle cycles after tx_done before the next grant.
- TIMEOUT_CYCLES, 65535: max cycles in WAIT_DONE before abort (16-bit counter).
- MAX_PAYLOAD, 1472: largest legal tx byte count.

Ports (clk, rst first; one clock; reset is synchronous and active-high):
- clk  in  1  system clock, same domain as the transmit engine
- rst  in  1  synchronous active-high reset
- srcN_req  in  1  (N=0,1) packet ready; level, held until srcN_done
- srcN_byte_num  in  16  payload bytes
- srcN_des_mac  in  48  destination MAC (0 = engine default)
- srcN_des_ip  in  32  destination IP (0 = engine default)
- srcN_data  in  32  source FIFO read data, big-endian byte order
- srcN_grant  out  1  source owns the engine
- srcN_rd_en  out  1  read strobe for the source FIFO
- srcN_done  out  1  one-cycle pulse: packet finished, rejected or aborted
- tx_start_en  out  1  engine start
- tx_byte_num  out  16  latched payload length
- des_mac  out  48  latched destination MAC
- des_ip  out  32  latched destination IP
- tx_data  out  32  muxed data to engine
- tx_req  in  1  engine data request
- tx_done  in  1  engine frame-complete pulse
- busy  out  1  state ≠ IDLE
- len_err  out  1  pulse: granted request had illegal length
- timeout_err  out  1  pulse: watchdog expired
- pkt_cnt0, pkt_cnt1  out  16  packets completed per source; wrap at 0xFFFF→0

## Operation
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE: if any req, the arbiter picks the winner. If both are requesting, pick the source not granted last. After reset, last = 1, so src0 wins first.
  - If the winner's byte_num is 0 or > MAX_PAYLOAD: pulse srcN_done and len_err, leave tx_start_en low, update last, go to GAP.
  - Otherwise latch sel, tx_byte_num, des_mac and des_ip, set srcN_grant, update last, go to START.
- START: tx_start_en = 1 for exactly START_HOLD cycles, then go to WAIT_DONE.
- WAIT_DONE:
  - On tx_done: pulse srcN_done, increment pkt_cntN, drop grant, go to GAP.
  - If the watchdog reaches TIMEOUT_CYCLES first: pulse timeout_err and srcN_done, drop grant, go to GAP, do not increment pkt_cnt.
- GAP: count IFG_CYCLES, then go to IDLE.
- Forwarding, combinational, valid only while granted: srcN_rd_en = tx_req & srcN_grant; tx_data = sel ? src1_data : src0_data. With no grant, rd_en = 0 and tx_data holds the last sel.
- Latched outputs (tx_byte_num, des_mac, des_ip, sel) stay stable from grant until the next grant. The engine samples them late, so they must not change mid-frame.
- req deassert during a grant is ignored. tx_req and tx_done outside START/WAIT_DONE are ignored. tx_done during START is ignored; the engine cannot finish that early.
- rst mid-packet: return to IDLE, all outputs to reset values next cycle. The engine is reset by the same rst.

## Timing
- Reset values:
  - tx_start_en, grants, done pulses, busy, len_err, timeout_err: 0.
  - tx_byte_num, des_mac, des_ip, pkt_cnt: 0.
  - sel = 0, last = 1.
- A req seen high in IDLE at edge k gives srcN_grant = 1 and tx_start_en = 1 from cycle k+1 through k+START_HOLD.
- tx_done high at cycle d gives srcN_done = 1 at d+1 only, grant = 0 from d+1, and pkt_cnt updated at d+1.
- GAP occupies d+1 .. d+IFG_CYCLES. The next grant is at d+IFG_CYCLES+2 at the earliest.
- Watchdog counts from the first WAIT_DONE cycle. It expires when its value equals TIMEOUT_CYCLES−1, giving timeout_err on the following cycle.
- rd_en and tx_data: zero latency from tx_req and source data.

## Structure
- Package eth_tx_pkg holds:
  - the state enum (IDLE, START, WAIT_DONE, GAP);
  - MAX_UDP_PAYLOAD = 1472;
  - MIN_START_HOLD = 3.
- Sub-module rr_arb2 (2-way round-robin with last-grant register, advance on accept). Everything else is flat in the top module.

## Test plan
- Single src0 request, byte_num = 100, des_ip = 192.168.1.102 → tx_start_en high 4 cycles, tx_byte_num = 100, des_ip latched. tx_done at cycle d → src0_done at d+1, pkt_cnt0 = 1, next grant ≥ d+14.
- Both req held continuously → grants alternate 0,1,0,1 over 4 packets; pkt_cnt0 = pkt_cnt1 = 2.
- Forwarding: pulse tx_req 25 times while src1 is granted → src1_rd_en mirrors it exactly, src0_rd_en stays 0, tx_data equals src1_data every cycle.
- src0 byte_num = 0, then 1500 → len_err and src0_done pulses, no tx_start_en, grant passes to src1 next.
- Engine never asserts tx_done, TIMEOUT_CYCLES = 100 → timeout_err exactly 100 cycles after WAIT_DONE entry, pkt_cnt unchanged, scheduler recovers to IDLE.
- rst asserted in WAIT_DONE → next cycle all outputs at reset values, last = 1, so src0 wins the next simultaneous request.
